symbol_serializer: RTL

//   Double-buffered parallel-to-serial stage for the BPSK TX path.

---
 rtl/symbol_serializer_if.sv | 11 +
 rtl/symbol_serializer.sv | 82 ++++++++
 2 files changed

// File: rtl/symbol_serializer_if.sv
// symbol_serializer_if: valid/ready word stream feeding the symbol serializer
//   data_sig  WIDTH-bit word from the source
//   valid_sig source has a word on data_sig
//   ready_sig serializer hold buffer can accept a word
interface symbol_serializer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] data_sig;
    logic             valid_sig;
    logic             ready_sig;
    modport master(output data_sig, valid_sig, input ready_sig);
    modport slave(input data_sig, valid_sig, output ready_sig);
endinterface

// File: rtl/symbol_serializer.sv
// symbol_serializer: double-buffered parallel-to-serial stage, one bit per symbol strobe
//   clk_sig        system clock, rising edge
//   reset_sig      asynchronous reset, active-high
//   strobe_sig     symbol tick, single-cycle pulse
//   in_if          word stream (data_sig/valid_sig in, ready_sig out)
//   bit_sig        serial output bit, held for one symbol period
//   bit_valid_sig  bit_sig carries a data bit for this symbol
//   word_start_sig one-cycle pulse: first bit of a word is on bit_sig
//   underrun_sig   one-cycle pulse: strobe arrived with no data available
module symbol_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic                clk_sig,
    input  logic                reset_sig,
    input  logic                strobe_sig,
    symbol_serializer_if.slave  in_if,
    output logic                bit_sig,
    output logic                bit_valid_sig,
    output logic                word_start_sig,
    output logic                underrun_sig
);
    localparam int RW = $clog2(WIDTH + 1);
    typedef enum logic {EMPTY, SHIFTING} state_t;
    state_t           state, state_n;
    logic [RW-1:0]    rem, rem_n;
    logic [WIDTH-1:0] hold, shreg, shreg_n, src;
    logic             buf_full, buf_full_n, accept, load;
    logic             bit_n, bit_valid_n, word_start_n, underrun_n;
    assign in_if.ready_sig = !buf_full;
    always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
            state          <= EMPTY;
            rem            <= '0;
            hold           <= '0;
            shreg          <= '0;
            buf_full       <= 1'b0;
            bit_sig        <= 1'b0;
            bit_valid_sig  <= 1'b0;
            word_start_sig <= 1'b0;
            underrun_sig   <= 1'b0;
        end else begin
            state          <= state_n;
            rem            <= rem_n;
            shreg          <= shreg_n;
            buf_full       <= buf_full_n;
            bit_sig        <= bit_n;
            bit_valid_sig  <= bit_valid_n;
            word_start_sig <= word_start_n;
            underrun_sig   <= underrun_n;
            if (accept) hold <= in_if.data_sig;
        end
    end
    always_comb begin
        accept       = in_if.valid_sig && !buf_full;
        load         = strobe_sig && state == EMPTY && buf_full;
        // on a load the outgoing bit comes straight from the hold buffer
        src          = load ? hold : shreg;
        state_n      = state;
        rem_n        = rem;
        shreg_n      = shreg;
        buf_full_n   = accept ? 1'b1 : load ? 1'b0 : buf_full;
        bit_n        = bit_sig;
        bit_valid_n  = bit_valid_sig;
        word_start_n = 1'b0;
        underrun_n   = 1'b0;
        if (strobe_sig) begin
            if (state == SHIFTING || load) begin
                bit_n        = MSB_FIRST ? src[WIDTH-1] : src[0];
                bit_valid_n  = 1'b1;
                word_start_n = load;
                shreg_n      = MSB_FIRST ? {src[WIDTH-2:0], 1'b0} : {1'b0, src[WIDTH-1:1]};
                rem_n        = load ? RW'(WIDTH - 1) : rem - RW'(1);
                state_n      = (rem_n == '0) ? EMPTY : SHIFTING;
            end else begin
                bit_n       = 1'b0;
                bit_valid_n = 1'b0;
                underrun_n  = 1'b1;
            end
        end
    end
endmodule
